aes_req_arbiter: RTL and testbench
==================================

# aes_req_arbiter

Shares one AES encrypt pipeline and its key expander between two requesters. Sequences key loading (pulse to the expander, wait for its valid), grants 128-bit blocks round-robin into the pipeline, tags each in-flight block with its requester ID, and routes pipeline outputs back to the correct requester. Sits between the requester ports and the `AESEncryptPipe` / `ExpandKey` instances.

## Interface
- `MAX_INFLIGHT`, 16: max blocks inside the pipe; also tag FIFO depth (power of 2, ≥2)
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-high reset
- `req0_valid` / `req1_valid` in 1: requester has a block
- `req0_data` / `req1_data` in 128: plaintext, held while valid and not granted
- `req0_grant` / `req1_grant` out 1: combinational accept, at most one high per cycle
- `rsp0_valid` / `rsp1_valid` out 1: one-cycle result strobe per requester
- `rsp_data` out 128: ciphertext, qualified by the `rspN_valid` strobes
- `key_load` in 1: pulse to load a new key
- `key_in` in 256: key, sampled on the `key_load` cycle
- `key_busy` out 1: high whenever state ≠ RUN
- `err` out 1: sticky; set when `pipe_valid` arrives with the tag FIFO empty
- `xk_ready` out 1: one-cycle start pulse to the expander
- `xk_key` out 256: captured key, held stable
- `xk_valid` in 1: expander done
- `pipe_ready` out 1: block-issue strobe to the pipe
- `pipe_data` out 128: block to the pipe
- `pipe_valid` in 1: pipe output valid
- `pipe_dout` in 128: pipe output

## Operation
- States: IDLE, KEY_REQ, KEY_WAIT, RUN, DRAIN. Reset → IDLE.
- IDLE: no key loaded; grants held 0. `key_load` captures `key_in` into `xk_key` and moves to KEY_REQ.
- KEY_REQ: `xk_ready`=1 for exactly one cycle, then KEY_WAIT.
- KEY_WAIT: wait for `xk_valid`=1, then RUN. `key_load` is ignored here and in KEY_REQ.
- RUN:
  - `grantN` = `reqN_valid` & (inflight < `MAX_INFLIGHT`) & round-robin pick.
  - Both valid: grant the requester not granted last. The pointer resets to favour req0.
  - On grant: the next edge sets `pipe_ready`=1, `pipe_data`=granted data, pushes the ID into the tag FIFO, and increments inflight.
- RUN + `key_load`: capture the key, go to DRAIN, grant nothing from that cycle on.
- DRAIN: stay until inflight=0, then KEY_REQ. Responses keep returning during drain.
- Return path (any state):
  - `pipe_valid` pops the tag FIFO and decrements inflight.
  - Next cycle: `rspN_valid`=1 for the popped ID and `rsp_data`=`pipe_dout`.
- Same-cycle issue and return: inflight unchanged, FIFO push and pop both occur.
- Inflight counter: width clog2(`MAX_INFLIGHT`)+1, never wraps. At `MAX_INFLIGHT`, grants are 0.
- Empty-FIFO `pipe_valid`: set `err`, no pop, no `rsp` strobe, inflight unchanged (saturates at 0).

## Timing
- Reset values:
  - State IDLE; all grants, `rsp*_valid`, `xk_ready`, `pipe_ready`, `err` = 0.
  - `pipe_data`, `rsp_data`, `xk_key` = 0.
  - `key_busy` = 1; inflight = 0; FIFO empty; round-robin pointer favours req0.
- Reset mid-operation discards all in-flight tags and the key. The pipe and expander are reset by the same `reset`.
- Grant → `pipe_ready`: 1 cycle. `pipe_valid` → `rspN_valid`: 1 cycle.
- `key_load` → `xk_ready`, from IDLE: 1 cycle.
- `xk_valid` → first possible grant: the next cycle (state = RUN).
- `pipe_ready` is never high on two consecutive cycles for the same held request.

## Configuration
- `AES_ARB_STATS_EN`, defined: adds 32-bit output counters `stat_issued0`, `stat_issued1` (grants per requester) and `stat_stall` (cycles with any `reqN_valid` in RUN but no grant). Counters wrap modulo 2^32 and reset to 0.
- Not defined: the counters and their ports are absent. All other behaviour is identical.

## Test plan
- Reset, then `key_load` with `key_in`=256'd1:
  - `xk_ready` pulses one cycle later with `xk_key`=1.
  - Hold `xk_valid`=0 for 10 cycles → `key_busy` stays 1 and no grants.
  - `xk_valid` pulse → RUN.
- Single block, req0 `data`=128'h69, pipe model latency 14:
  - `pipe_ready` one cycle after the grant.
  - `rsp0_valid` and `rsp_data`=model output one cycle after `pipe_valid`; `rsp1_valid` never asserts.
- req0 and req1 both held valid for 8 cycles: grants alternate 0,1,0,1…; returned IDs match issue order.
- `MAX_INFLIGHT`=4, pipe latency 20, continuous req0: exactly 4 grants, then grants=0 until the first `pipe_valid`. An issue and a return in the same cycle keep inflight at 4.
- `key_load` with 3 blocks in flight:
  - No new grants; all 3 responses delivered.
  - `xk_ready` fires the cycle after inflight reaches 0, with the new key.
- `pipe_valid` with an empty FIFO → `err`=1 and stays set until `reset`; no `rsp` strobe.

Source files
------------

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: shares one AES encrypt pipe and its key expander between
// two requesters. Sequences key expansion, grants blocks round-robin, tags
// every in-flight block with its requester ID and steers pipe results back.
// Optional build macro: AES_ARB_STATS_EN adds grant/stall statistics counters.
//
// Handshake semantics: a requester raises reqN_valid with reqN_data and holds
// both until reqN_grant is seen high in the same cycle; that cycle's rising
// edge is the transfer. pipe_ready and xk_ready are one-cycle strobes with no
// back-pressure; pipe_valid and xk_valid are one-cycle strobes from the pipe
// and expander; rspN_valid is a one-cycle strobe qualifying rsp_data.
module aes_req_arbiter #(
    parameter int MAX_INFLIGHT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req1_valid,
    input  logic [127:0] req0_data,
    input  logic [127:0] req1_data,
    output logic         req0_grant,
    output logic         req1_grant,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [127:0] rsp_data,
    input  logic         key_load,
    input  logic [255:0] key_in,
    output logic         key_busy,
    output logic         err,
    output logic         xk_ready,
    output logic [255:0] xk_key,
    input  logic         xk_valid,
    output logic         pipe_ready,
    output logic [127:0] pipe_data,
    input  logic         pipe_valid,
    input  logic [127:0] pipe_dout,
`ifdef AES_ARB_STATS_EN
    output logic [31:0]  stat_issued0,
    output logic [31:0]  stat_issued1,
    output logic [31:0]  stat_stall,
`endif
    output logic [2:0]   dbg_state
);

    localparam int AW = $clog2(MAX_INFLIGHT);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KEY_REQ  = 3'd1,
        ST_KEY_WAIT = 3'd2,
        ST_RUN      = 3'd3,
        ST_DRAIN    = 3'd4
    } state_t;

    state_t         r_state;
    logic           r_xk_ready;
    logic [255:0]   r_xk_key;
    logic           r_prio1;       // 1: req1 wins a tie next time
    logic           r_pipe_ready;
    logic [127:0]   r_pipe_data;
    logic           r_tag_mem [MAX_INFLIGHT];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_inflight;    // doubles as tag FIFO occupancy
    logic           r_rsp0_valid;
    logic           r_rsp1_valid;
    logic [127:0]   r_rsp_data;
    logic           r_err;

    logic           w_room;
    logic           w_can_grant;
    logic           w_grant0;
    logic           w_grant1;
    logic           w_push;
    logic           w_empty;
    logic           w_pop;
    logic           w_pop_id;

    // Grant decision: only in RUN, never on a key_load cycle, never when full.
    always_comb begin
        w_room      = r_inflight < CW'(MAX_INFLIGHT);
        w_can_grant = (r_state == ST_RUN) && !key_load && w_room;
        w_grant0    = w_can_grant && req0_valid && (!req1_valid || !r_prio1);
        w_grant1    = w_can_grant && req1_valid && (!req0_valid || r_prio1);
        w_push      = w_grant0 || w_grant1;
        w_empty     = (r_inflight == '0);
        w_pop       = pipe_valid && !w_empty;
        w_pop_id    = r_tag_mem[r_rd_ptr];
    end

    // Key sequencing FSM with registered expander strobe and captured key.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_xk_ready <= 1'b0;
            r_xk_key   <= '0;
        end else begin
            r_xk_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (key_load) begin
                        r_xk_key   <= key_in;
                        r_xk_ready <= 1'b1;
                        r_state    <= ST_KEY_REQ;
                    end
                end
                ST_KEY_REQ: begin
                    r_state <= ST_KEY_WAIT;
                end
                ST_KEY_WAIT: begin
                    if (xk_valid) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (key_load) begin
                        r_xk_key <= key_in;
                        r_state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Old-key blocks must all leave the pipe before re-expansion.
                    if (w_empty) begin
                        r_xk_ready <= 1'b1;
                        r_state    <= ST_KEY_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Issue path: forward the granted block and advance the round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_ready <= 1'b0;
            r_pipe_data  <= '0;
            r_prio1      <= 1'b0;
        end else begin
            r_pipe_ready <= w_push;
            if (w_push) begin
                r_pipe_data <= w_grant1 ? req1_data : req0_data;
                r_prio1     <= w_grant0;
            end
        end
    end

    // Tag storage: requester ID of each issued block, in issue order.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_grant1;
        end
    end

    // Tag FIFO pointers and in-flight count; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Return path: steer pipe output to the tagged requester; flag orphans.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_data   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_rsp0_valid <= w_pop && !w_pop_id;
            r_rsp1_valid <= w_pop && w_pop_id;
            if (w_pop) begin
                r_rsp_data <= pipe_dout;
            end
            if (pipe_valid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef AES_ARB_STATS_EN
    logic [31:0] r_stat_issued0;
    logic [31:0] r_stat_issued1;
    logic [31:0] r_stat_stall;

    // Free-running statistics; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_issued0 <= '0;
            r_stat_issued1 <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (w_grant0) begin
                r_stat_issued0 <= r_stat_issued0 + 32'd1;
            end
            if (w_grant1) begin
                r_stat_issued1 <= r_stat_issued1 + 32'd1;
            end
            if ((r_state == ST_RUN) && (req0_valid || req1_valid) && !w_push) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_issued0 = r_stat_issued0;
    assign stat_issued1 = r_stat_issued1;
    assign stat_stall   = r_stat_stall;
`endif

    assign req0_grant = w_grant0;
    assign req1_grant = w_grant1;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_data   = r_rsp_data;
    assign key_busy   = (r_state != ST_RUN);
    assign err        = r_err;
    assign xk_ready   = r_xk_ready;
    assign xk_key     = r_xk_key;
    assign pipe_ready = r_pipe_ready;
    assign pipe_data  = r_pipe_data;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Testbench for aes_req_arbiter: directed vectors, a behavioural pipe with
// programmable latency, and a scoreboard of expected {id, ciphertext} pairs.
module tb_aes_req_arbiter;

    localparam int MAXI = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         req0_valid, req1_valid;
    logic [127:0] req0_data, req1_data;
    logic         req0_grant, req1_grant;
    logic         rsp0_valid, rsp1_valid;
    logic [127:0] rsp_data;
    logic         key_load;
    logic [255:0] key_in;
    logic         key_busy, err, xk_ready;
    logic [255:0] xk_key;
    logic         xk_valid;
    logic         pipe_ready;
    logic [127:0] pipe_data;
    logic         pipe_valid;
    logic [127:0] pipe_dout;
    logic [2:0]   dbg_state;
`ifdef AES_ARB_STATS_EN
    logic [31:0]  stat_issued0, stat_issued1, stat_stall;
`endif

    aes_req_arbiter #(.MAX_INFLIGHT(MAXI)) dut (
        .clk(clk),
        .reset(reset),
        .req0_valid(req0_valid),
        .req1_valid(req1_valid),
        .req0_data(req0_data),
        .req1_data(req1_data),
        .req0_grant(req0_grant),
        .req1_grant(req1_grant),
        .rsp0_valid(rsp0_valid),
        .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data),
        .key_load(key_load),
        .key_in(key_in),
        .key_busy(key_busy),
        .err(err),
        .xk_ready(xk_ready),
        .xk_key(xk_key),
        .xk_valid(xk_valid),
        .pipe_ready(pipe_ready),
        .pipe_data(pipe_data),
        .pipe_valid(pipe_valid),
        .pipe_dout(pipe_dout),
`ifdef AES_ARB_STATS_EN
        .stat_issued0(stat_issued0),
        .stat_issued1(stat_issued1),
        .stat_stall(stat_stall),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Cipher stand-in used by the behavioural pipe.
    function automatic logic [127:0] model(input logic [127:0] d);
        return ~d ^ {d[63:0], d[127:64]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural pipe ----------------
    int           cyc = 0;
    int           pipe_lat = 14;
    logic         force_pv = 1'b0;
    logic         pv_forced = 1'b0;
    int           due_q[$];
    logic [127:0] dat_q[$];

    initial begin
        pipe_valid = 1'b0;
        pipe_dout  = '0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (reset) begin
                due_q.delete();
                dat_q.delete();
                pipe_valid = 1'b0;
                pv_forced  = 1'b0;
            end else begin
                if (pipe_ready) begin
                    due_q.push_back(cyc + pipe_lat);
                    dat_q.push_back(pipe_data);
                end
                if (force_pv) begin
                    pipe_valid = 1'b1;
                    pipe_dout  = 128'hdead_beef;
                    pv_forced  = 1'b1;
                end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    pipe_valid = 1'b1;
                    pipe_dout  = model(dat_q[0]);
                    pv_forced  = 1'b0;
                    void'(due_q.pop_front());
                    void'(dat_q.pop_front());
                end else begin
                    pipe_valid = 1'b0;
                    pv_forced  = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard / response monitor ----------------
    logic [128:0] exp_q[$];   // {id, ciphertext}
    logic         mon_pv_prev = 1'b0;
    int           last_rsp_cyc = -1;
    logic [127:0] last_rsp_data = '0;
    logic         last_rsp_id = 1'b0;
    int           n_rsp1 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_pv_prev = 1'b0;
            end else begin
                check("rsp_strobe_timing", rsp0_valid | rsp1_valid, mon_pv_prev);
                check("rsp_onehot", rsp0_valid & rsp1_valid, 1'b0);
                if (rsp0_valid || rsp1_valid) begin
                    if (rsp1_valid) n_rsp1++;
                    last_rsp_cyc  = cyc;
                    last_rsp_data = rsp_data;
                    last_rsp_id   = rsp1_valid;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got strobe id=%0d data=%0h, expected none", rsp1_valid, rsp_data);
                    end else begin
                        logic [128:0] e;
                        e = exp_q.pop_front();
                        check("rsp_id", rsp1_valid, e[128]);
                        check("rsp_data", rsp_data, e[127:0]);
                    end
                end
                mon_pv_prev = pipe_valid && !pv_forced;
            end
        end
    end

    // ---------------- grant / issue monitor ----------------
    logic         g_prev = 1'b0;
    logic [127:0] g_prev_data = '0;
    logic         log_en = 1'b0;
    int           grant_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                g_prev = 1'b0;
            end else begin
                check("pipe_ready_latency", pipe_ready, g_prev);
                if (g_prev) check("pipe_data", pipe_data, g_prev_data);
                check("grant_onehot", req0_grant & req1_grant, 1'b0);
                check("grant_while_busy", (req0_grant | req1_grant) & key_busy, 1'b0);
                g_prev      = req0_grant | req1_grant;
                g_prev_data = req1_grant ? req1_data : req0_data;
                if (log_en && g_prev) grant_log.push_back(req1_grant ? 1 : 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic id, input logic [127:0] d);
        int   t = 0;
        logic done = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_data = d; end
        while (!done) begin
            @(negedge clk);
            if (id ? req1_grant : req0_grant) begin
                exp_q.push_back({id, model(d)});
                done = 1'b1;
            end else if (t > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: got no grant for id=%0d, expected grant", id);
                done = 1'b1;
            end
            t++;
            tick();
        end
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            tick();
            t++;
        end
        check("drain_timeout_pending", exp_q.size(), 0);
        tick();
    endtask

    // ---------------- main sequence ----------------
    localparam logic [255:0] KEY2 = 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_0011_2233_4455_6677_8899_aabb_ccdd_eeff;

    initial begin
        int cnt;
        logic seen;
        int t;
        int drain_grants;
        int xk_cyc;

        reset = 1'b1; req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
        key_load = 0; key_in = '0; xk_valid = 0;
        repeat (3) tick();

        // Reset values
        @(negedge clk);
        check("rst_state", dbg_state, 3'd0);
        check("rst_key_busy", key_busy, 1'b1);
        check("rst_xk_ready", xk_ready, 1'b0);
        check("rst_pipe_ready", pipe_ready, 1'b0);
        check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
        check("rst_err", err, 1'b0);
        check("rst_pipe_data", pipe_data, 128'd0);
        check("rst_rsp_data", rsp_data, 128'd0);
        check("rst_xk_key", xk_key, 256'd0);
        tick();
        reset = 1'b0;

        // Key load from IDLE
        tick();
        key_in = 256'd1; key_load = 1'b1;
        @(negedge clk);
        check("xk_ready_before_load_edge", xk_ready, 1'b0);
        tick();
        key_load = 1'b0; key_in = 256'hbad;
        @(negedge clk);
        check("xk_ready_pulse", xk_ready, 1'b1);
        check("xk_key_captured", xk_key, 256'd1);
        check("state_key_req", dbg_state, 3'd1);
        tick();
        @(negedge clk);
        check("xk_ready_one_cycle", xk_ready, 1'b0);
        check("state_key_wait", dbg_state, 3'd2);
        tick();

        // Expander silent for 10 cycles; requests and key_load must be ignored
        req0_valid = 1'b1; req0_data = 128'h55;
        for (int i = 0; i < 10; i++) begin
            key_load = (i == 3);
            key_in   = 256'hbad;
            @(negedge clk);
            check("wait_key_busy", key_busy, 1'b1);
            check("wait_no_grant", req0_grant, 1'b0);
            tick();
        end
        key_load = 1'b0;
        req0_valid = 1'b0;
        check("key_load_ignored_in_wait", xk_key, 256'd1);
        xk_valid = 1'b1;
        tick();
        xk_valid = 1'b0;
        @(negedge clk);
        check("state_run", dbg_state, 3'd3);
        check("run_key_busy", key_busy, 1'b0);
        tick();

        // Single block on req0, latency 14
        pipe_lat = 14;
        send(1'b0, 128'h69);
        wait_idle();
        check("single_rsp_id", last_rsp_id, 1'b0);
        check("single_rsp_data", last_rsp_data, 128'hFFFFFFFFFFFFFF96_FFFFFFFFFFFFFF96);
        check("single_no_rsp1", n_rsp1, 0);

        // Both requesters held: last grant was req0, so req1 leads
        pipe_lat = 2;
        log_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) send(1'b0, 128'h1000 + 128'(i));
            end
            begin
                for (int i = 0; i < 4; i++) send(1'b1, 128'h2000 + 128'(i));
            end
        join
        log_en = 1'b0;
        wait_idle();
        check("rr_grant_count", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size(); i++) begin
            check("rr_grant_order", grant_log[i], (i % 2 == 0) ? 1 : 0);
        end

        // In-flight limit: MAX 4, latency 20, continuous req0
        pipe_lat = 20;
        cnt = 0; seen = 1'b0; t = 0;
        req0_valid = 1'b1; req0_data = 128'h4000;
        while (!seen && t < 80) begin
            @(negedge clk);
            if (pipe_valid) seen = 1'b1;
            if (req0_grant) begin
                exp_q.push_back({1'b0, model(req0_data)});
                cnt++;
                tick();
                req0_data = req0_data + 128'd1;
            end else begin
                tick();
            end
            t++;
        end
        check("max_first_return_seen", seen, 1'b1);
        check("max_inflight_grants", cnt, 4);
        @(negedge clk);
        check("grant_after_return", req0_grant, 1'b1);
        if (req0_grant) exp_q.push_back({1'b0, model(req0_data)});
        tick();
        req0_valid = 1'b0;
        wait_idle();
        check("max_no_err", err, 1'b0);

        // Key reload with 3 blocks in flight
        pipe_lat = 14;
        send(1'b0, 128'hA0);
        send(1'b1, 128'hB1);
        send(1'b0, 128'hC2);
        key_load = 1'b1; key_in = KEY2;
        req1_valid = 1'b1; req1_data = 128'hD3;
        @(negedge clk);
        check("no_grant_on_keyload", req1_grant, 1'b0);
        tick();
        key_load = 1'b0; key_in = '0;
        drain_grants = 0; xk_cyc = -1; t = 0;
        while (xk_cyc < 0 && t < 100) begin
            @(negedge clk);
            if (req0_grant || req1_grant) drain_grants++;
            if (xk_ready) xk_cyc = cyc;
            t++;
        end
        check("drain_no_grants", drain_grants, 0);
        check("drain_all_rsp", exp_q.size(), 0);
        check("drain_xk_ready_timing", xk_cyc, last_rsp_cyc + 1);
        check("drain_new_key", xk_key, KEY2);
        check("drain_state_key_req", dbg_state, 3'd1);
        tick();
        req1_valid = 1'b0;
        xk_valid = 1'b1;
        tick();
        xk_valid = 1'b0;
        @(negedge clk);
        check("reload_state_run", dbg_state, 3'd3);
        tick();

        // Orphan pipe_valid with empty FIFO
        force_pv = 1'b1;
        tick();
        force_pv = 1'b0;
        @(negedge clk);
        check("err_set", err, 1'b1);
        repeat (5) tick();
        check("err_sticky", err, 1'b1);
        send(1'b1, 128'h77);
        wait_idle();
        check("err_sticky_after_traffic", err, 1'b1);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("err_cleared_by_reset", err, 1'b0);
        check("reset_state_idle", dbg_state, 3'd0);
        check("reset_key_busy", key_busy, 1'b1);
        check("reset_xk_key", xk_key, 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "time limit");
    end

endmodule
